// File: rtl/ram_data_arbiter_pkg.sv
// Shared constants for the data-RAM arbiter: read-owner tags, FSM states and
// starvation counter sizing.
package ram_data_arbiter_pkg;

    localparam int STARVE_W = 8;

    localparam logic [0:0] OWN_CORE = 1'b0;
    localparam logic [0:0] OWN_LDR  = 1'b1;

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef logic [STARVE_W-1:0] starve_t;

    // A granted access that needs a data return one cycle later.
    function automatic logic is_read(input logic gnt, input logic we);
        return gnt & ~we;
    endfunction

endpackage

// File: rtl/ram_data_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data RAM.
interface ram_data_arbiter_if #(
    parameter int MEM = 19
);
    logic            core_req;
    logic            core_we;
    logic [MEM-1:0]  core_addr;
    logic [31:0]     core_wdata;
    logic            core_gnt;
    logic            core_rvalid;
    logic [31:0]     core_rdata;

    logic            ldr_req;
    logic            ldr_we;
    logic [MEM-1:0]  ldr_addr;
    logic [31:0]     ldr_wdata;
    logic            ldr_gnt;
    logic            ldr_rvalid;
    logic [31:0]     ldr_rdata;

    logic            ldr_done;
    logic            boot_done;

    logic            ram_we;
    logic [MEM-1:0]  ram_addr;
    logic [31:0]     ram_din;
    logic [31:0]     ram_dout;

    // Arbiter side.
    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_rdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        input  ldr_done,
        output boot_done,
        output ram_we, ram_addr, ram_din,
        input  ram_dout
    );

    // Requester / RAM side.
    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_rdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        output ldr_done,
        input  boot_done,
        input  ram_we, ram_addr, ram_din,
        output ram_dout
    );

endinterface

// File: rtl/ram_data_arbiter_rd_return_tag.sv
// Remembers who issued the read granted last cycle and raises that owner's
// rvalid alongside the RAM's registered output.
module rd_return_tag #(
    parameter int N_OWN = 2,
    parameter int OW    = (N_OWN > 1) ? $clog2(N_OWN) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_issue,
    input  logic [OW-1:0]     i_owner,
    input  logic [31:0]       i_rdata,
    output logic [N_OWN-1:0]  o_rvalid,
    output logic [31:0]       o_rdata
);

    logic          r_valid;
    logic [OW-1:0] r_owner;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_owner <= '0;
        end else begin
            r_valid <= i_issue;
            if (i_issue) begin
                r_owner <= i_owner;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_OWN; gi++) begin : g_demux
            assign o_rvalid[gi] = r_valid && (r_owner == OW'(gi));
        end
    endgenerate

    // The RAM already registers its output, so data is passed straight through.
    assign o_rdata = i_rdata;

endmodule

// File: rtl/ram_data_arbiter.sv
// Data-RAM arbiter: loader-only BOOT phase, then core-priority RUN phase with
// a starvation guarantee for the loader.
module ram_data_arbiter
    import ram_data_arbiter_pkg::*;
#(
    parameter int MEM    = 19,
    parameter int STARVE = 8
) (
    input  logic               clk,
    input  logic               rstn,
    ram_data_arbiter_if.slave  bus
);

    logic [0:0] r_state;
    starve_t    r_starve;

    logic       w_run;
    logic       w_forced;
    logic       w_core_gnt;
    logic       w_ldr_gnt;
    logic       w_rd_issue;
    logic [0:0] w_rd_owner;
    logic [1:0] w_rvalid;
    logic [31:0] w_rdata;

    assign w_run    = (r_state == ST_RUN);
    assign w_forced = w_run && bus.ldr_req && (r_starve == starve_t'(STARVE));

    // Grants are gated by rstn so nothing leaks onto the RAM while in reset.
    always_comb begin
        w_core_gnt = 1'b0;
        w_ldr_gnt  = 1'b0;
        if (rstn) begin
            if (!w_run) begin
                w_ldr_gnt = bus.ldr_req;
            end else if (w_forced) begin
                w_ldr_gnt = 1'b1;
            end else begin
                w_core_gnt = bus.core_req;
                w_ldr_gnt  = bus.ldr_req & ~bus.core_req;
            end
        end
    end

    always_comb begin
        bus.ram_we   = 1'b0;
        bus.ram_addr = '0;
        bus.ram_din  = '0;
        if (w_core_gnt) begin
            bus.ram_we   = bus.core_we;
            bus.ram_addr = bus.core_addr;
            bus.ram_din  = bus.core_wdata;
        end else if (w_ldr_gnt) begin
            bus.ram_we   = bus.ldr_we;
            bus.ram_addr = bus.ldr_addr;
            bus.ram_din  = bus.ldr_wdata;
        end
    end

    // RUN is terminal; only reset returns to BOOT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_BOOT;
        end else if (!w_run && bus.ldr_done) begin
            r_state <= ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_starve <= '0;
        end else if (w_ldr_gnt || !bus.ldr_req) begin
            r_starve <= '0;
        end else if (r_starve < starve_t'(STARVE)) begin
            r_starve <= r_starve + starve_t'(1);
        end
    end

    assign w_rd_issue = is_read(w_core_gnt, bus.core_we) | is_read(w_ldr_gnt, bus.ldr_we);
    assign w_rd_owner = w_ldr_gnt ? OWN_LDR : OWN_CORE;

    rd_return_tag #(
        .N_OWN (2)
    ) u_rd_return_tag (
        .clk      (clk),
        .rstn     (rstn),
        .i_issue  (w_rd_issue),
        .i_owner  (w_rd_owner),
        .i_rdata  (bus.ram_dout),
        .o_rvalid (w_rvalid),
        .o_rdata  (w_rdata)
    );

    assign bus.core_gnt    = w_core_gnt;
    assign bus.ldr_gnt     = w_ldr_gnt;
    assign bus.core_rvalid = w_rvalid[OWN_CORE];
    assign bus.ldr_rvalid  = w_rvalid[OWN_LDR];
    assign bus.core_rdata  = w_rdata;
    assign bus.ldr_rdata   = w_rdata;
    assign bus.boot_done   = w_run;

endmodule

// File: tb/tb_ram_data_arbiter.sv
// Directed bench for ram_data_arbiter with a behavioural 1-cycle RAM and a
// queue-based read-return scoreboard.
module tb_ram_data_arbiter;

    localparam int MEM = 19;

    logic clk;
    logic rstn;

    ram_data_arbiter_if #(.MEM(MEM)) bus ();

    ram_data_arbiter #(
        .MEM    (MEM),
        .STARVE (8)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ram_data: synchronous write, registered read.
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_addr[7:0]] <= bus.ram_din;
        bus.ram_dout <= ram[bus.ram_addr[7:0]];
    end

    typedef struct {
        logic        own;   // 0 = core, 1 = loader
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", name, act);
        end
    endtask

    task automatic expect_rd(input logic own, input logic [31:0] data);
        exp_t e;
        e.own  = own;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [MEM-1:0] ca, input logic [31:0] cd,
                         input logic lr, input logic lw, input logic [MEM-1:0] la, input logic [31:0] ld,
                         input logic done);
        bus.core_req   = cr;
        bus.core_we    = cw;
        bus.core_addr  = ca;
        bus.core_wdata = cd;
        bus.ldr_req    = lr;
        bus.ldr_we     = lw;
        bus.ldr_addr   = la;
        bus.ldr_wdata  = ld;
        bus.ldr_done   = done;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every rvalid pops one expected return.
    always @(negedge clk) begin
        if (bus.core_rvalid || bus.ldr_rvalid) begin
            n_tests++;
            if (bus.core_rvalid && bus.ldr_rvalid) begin
                n_fail++;
                $display("[TB] FAIL rvalid_both: core_rvalid=1 ldr_rvalid=1, required at most one");
            end else if (q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL rvalid_unexpected: core_rvalid=%0b ldr_rvalid=%0b, required none",
                         bus.core_rvalid, bus.ldr_rvalid);
            end else begin
                exp_t e;
                logic [31:0] d;
                e = q.pop_front();
                d = bus.ldr_rvalid ? bus.ldr_rdata : bus.core_rdata;
                if (bus.ldr_rvalid !== e.own || d !== e.data) begin
                    n_fail++;
                    $display("[TB] FAIL rvalid_return: owner=%0b data=0x%08h, required owner=%0b data=0x%08h",
                             bus.ldr_rvalid, d, e.own, e.data);
                end else begin
                    $display("[TB] ok   read return owner=%0b data=0x%08h", e.own, d);
                end
            end
        end
    end

    initial begin
        rstn = 1'b0;
        bus.ram_dout = '0;
        // Boot lockout stimulus is already applied during reset.
        drive(1'b1, 1'b0, 19'h10, 32'h0, 1'b1, 1'b1, 19'h10, 32'hDEADBEEF, 1'b0);
        #2;
        chk("rst_core_gnt", bus.core_gnt, 0);
        chk("rst_ldr_gnt", bus.ldr_gnt, 0);
        chk("rst_boot_done", bus.boot_done, 0);
        chk("rst_core_rvalid", bus.core_rvalid, 0);
        chk("rst_ldr_rvalid", bus.ldr_rvalid, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Boot lockout: loader wins although core requests.
        @(negedge clk);
        chk("boot_ldr_gnt", bus.ldr_gnt, 1);
        chk("boot_core_gnt", bus.core_gnt, 0);
        chk("boot_ram_we", bus.ram_we, 1);
        chk("boot_ram_addr", 32'(bus.ram_addr), 32'h10);
        chk("boot_ram_din", bus.ram_din, 32'hDEADBEEF);
        chk("boot_done_low", bus.boot_done, 0);
        tick();

        drive(1'b1, 1'b0, 19'h10, 32'h0, 1'b1, 1'b1, 19'h11, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        chk("boot_ldr_gnt2", bus.ldr_gnt, 1);
        chk("boot_core_gnt2", bus.core_gnt, 0);
        tick();

        // Loader write in the ldr_done cycle must still land.
        drive(1'b0, 1'b0, 19'h0, 32'h0, 1'b1, 1'b1, 19'h12, 32'h0BADF00D, 1'b1);
        @(negedge clk);
        chk("done_ldr_gnt", bus.ldr_gnt, 1);
        chk("done_boot_done", bus.boot_done, 0);
        tick();

        // Boot exit: core read of 0x10.
        drive(1'b1, 1'b0, 19'h10, 32'h0, 1'b0, 1'b0, 19'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("run_boot_done", bus.boot_done, 1);
        chk("run_core_gnt", bus.core_gnt, 1);
        expect_rd(1'b0, 32'hDEADBEEF);
        tick();

        drive(1'b0, 1'b0, 19'h0, 32'h0, 1'b0, 1'b0, 19'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("idle_ram_we", bus.ram_we, 0);
        chk("idle_ram_addr", 32'(bus.ram_addr), 0);
        chk("idle_ram_din", bus.ram_din, 0);
        tick();

        // Core priority with the starvation slot on cycle 9.
        drive(1'b1, 1'b0, 19'h10, 32'h0, 1'b1, 1'b0, 19'h11, 32'h0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 9) begin
                chk($sformatf("prio_c%0d_core_gnt", i), bus.core_gnt, 0);
                chk($sformatf("prio_c%0d_ldr_gnt", i), bus.ldr_gnt, 1);
                expect_rd(1'b1, 32'hCAFEF00D);
            end else begin
                chk($sformatf("prio_c%0d_core_gnt", i), bus.core_gnt, 1);
                chk($sformatf("prio_c%0d_ldr_gnt", i), bus.ldr_gnt, 0);
                expect_rd(1'b0, 32'hDEADBEEF);
            end
            tick();
        end

        // Interleaved reads core / loader / core.
        drive(1'b1, 1'b0, 19'h10, 32'h0, 1'b0, 1'b0, 19'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("il_core_gnt_a", bus.core_gnt, 1);
        expect_rd(1'b0, 32'hDEADBEEF);
        tick();
        drive(1'b0, 1'b0, 19'h0, 32'h0, 1'b1, 1'b0, 19'h11, 32'h0, 1'b0);
        @(negedge clk);
        chk("il_ldr_gnt_b", bus.ldr_gnt, 1);
        expect_rd(1'b1, 32'hCAFEF00D);
        tick();
        drive(1'b1, 1'b0, 19'h12, 32'h0, 1'b0, 1'b0, 19'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("il_core_gnt_c", bus.core_gnt, 1);
        expect_rd(1'b0, 32'h0BADF00D);
        tick();
        drive(1'b0, 1'b0, 19'h0, 32'h0, 1'b0, 1'b0, 19'h0, 32'h0, 1'b0);
        tick();

        // Write then read of the same address.
        drive(1'b1, 1'b1, 19'h20, 32'h5, 1'b0, 1'b0, 19'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("wr_core_gnt", bus.core_gnt, 1);
        chk("wr_ram_we", bus.ram_we, 1);
        tick();
        drive(1'b1, 1'b0, 19'h20, 32'h0, 1'b0, 1'b0, 19'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("rd_ram_we", bus.ram_we, 0);
        expect_rd(1'b0, 32'h5);
        tick();
        drive(1'b0, 1'b0, 19'h0, 32'h0, 1'b0, 1'b0, 19'h0, 32'h0, 1'b0);
        tick();
        tick();

        // Reset between grant and return: the pending rvalid is dropped.
        drive(1'b1, 1'b0, 19'h10, 32'h0, 1'b0, 1'b0, 19'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("mr_core_gnt", bus.core_gnt, 1);
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("mr_core_rvalid_now", bus.core_rvalid, 0);
        chk("mr_core_gnt_rst", bus.core_gnt, 0);
        chk("mr_boot_done_rst", bus.boot_done, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("mr_core_gnt_boot", bus.core_gnt, 0);
        chk("mr_boot_done_boot", bus.boot_done, 0);
        chk("mr_core_rvalid_after", bus.core_rvalid, 0);
        tick();
        drive(1'b0, 1'b0, 19'h0, 32'h0, 1'b0, 1'b0, 19'h0, 32'h0, 1'b0);
        repeat (3) tick();

        chk("sb_pending_returns", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
